// File: rtl/i2c_regmap_cdc.sv
// Register map behind the I2C slave: brings scl-domain writes into clk, holds
// CTRL/STATUS/IRQ_EN/WR_CNT/CHIP_ID, and returns registered read data.
module i2c_regmap_cdc #(
    parameter int          NUM_REGS    = 16,
    parameter logic [7:0]  CHIP_ID     = 8'hA5,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_wdata,
    input  logic [7:0]            addr,
    input  logic [7:0]            wdata,
    input  logic                  i2c_active,
    input  logic [7:0]            hw_status,
    output logic [7:0]            rdata,
    output logic [NUM_REGS*8-1:0] regs_out,
    output logic                  wr_pulse,
    output logic [7:0]            wr_addr,
    output logic                  txn_done,
    output logic                  irq
);

    localparam logic [7:0] A_STATUS  = 8'hF0;
    localparam logic [7:0] A_IRQ_EN  = 8'hF1;
    localparam logic [7:0] A_WR_CNT  = 8'hF2;
    localparam logic [7:0] A_CHIP_ID = 8'hFE;
    localparam logic [8:0] N_CTRL    = 9'(NUM_REGS);

    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_act_sync;
    logic                   r_wr_prev;
    logic                   r_act_prev;
    logic [SYNC_STAGES:0]   r_prime;
    logic [7:0]             r_ctrl [NUM_REGS];
    logic [7:0]             r_status;
    logic [7:0]             r_irq_en;
    logic [7:0]             r_wr_cnt;
    logic [7:0]             r_rdata;
    logic                   r_wr_pulse;
    logic [7:0]             r_wr_addr;
    logic                   r_txn_done;
    logic                   r_irq;

    logic                   w_armed;
    logic                   w_wr_rise;
    logic                   w_act_fall;
    logic                   w_sel_ctrl;
    logic                   w_sel_map;
    logic                   w_accept;
    logic [7:0]             w_status_clr;
    logic [7:0]             w_rd_mux;

    // Synchronizers and edge flops; r_prime holds edge detection off until
    // both the sync chain and the edge flop carry post-reset samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_sync  <= '0;
            r_act_sync <= '0;
            r_wr_prev  <= 1'b1;
            r_act_prev <= 1'b1;
            r_prime    <= '0;
        end else begin
            r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], wr_en_wdata};
            r_act_sync <= {r_act_sync[SYNC_STAGES-2:0], i2c_active};
            r_wr_prev  <= r_wr_sync[SYNC_STAGES-1];
            r_act_prev <= r_act_sync[SYNC_STAGES-1];
            r_prime    <= {r_prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_armed    = r_prime[SYNC_STAGES];
    assign w_wr_rise  = w_armed & r_wr_sync[SYNC_STAGES-1] & ~r_wr_prev;
    assign w_act_fall = w_armed & ~r_act_sync[SYNC_STAGES-1] & r_act_prev;

    // Address decode, write acceptance and STATUS clear mask.
    always_comb begin
        w_sel_ctrl   = ({1'b0, addr} < N_CTRL);
        w_sel_map    = w_sel_ctrl || (addr == A_STATUS) || (addr == A_IRQ_EN) || (addr == A_WR_CNT);
        w_accept     = w_wr_rise & w_sel_map;
        w_status_clr = 8'h00;
        if (w_accept && (addr == A_STATUS)) begin
            w_status_clr = wdata;
        end else begin
            w_status_clr = 8'h00;
        end
    end

    // Read mux on the live scl-domain address; re-registered every clk.
    always_comb begin
        w_rd_mux = 8'h00;
        if (w_sel_ctrl) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (addr == 8'(n)) begin
                    w_rd_mux = r_ctrl[n];
                end else begin
                    w_rd_mux = w_rd_mux;
                end
            end
        end else begin
            case (addr)
                A_STATUS:  w_rd_mux = r_status;
                A_IRQ_EN:  w_rd_mux = r_irq_en;
                A_WR_CNT:  w_rd_mux = r_wr_cnt;
                A_CHIP_ID: w_rd_mux = CHIP_ID;
                default:   w_rd_mux = 8'h00;
            endcase
        end
    end

    // Register file, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                r_ctrl[n] <= 8'h00;
            end
            r_status   <= 8'h00;
            r_irq_en   <= 8'h00;
            r_wr_cnt   <= 8'h00;
            r_rdata    <= 8'h00;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_txn_done <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                if (w_accept && w_sel_ctrl && (addr == 8'(n))) begin
                    r_ctrl[n] <= wdata;
                end
            end
            // Set wins over write-1-to-clear in the same cycle.
            r_status <= (r_status & ~w_status_clr) | hw_status;
            if (w_accept && (addr == A_IRQ_EN)) begin
                r_irq_en <= wdata;
            end
            if (w_accept) begin
                r_wr_cnt  <= (addr == A_WR_CNT) ? 8'h00 : r_wr_cnt + 8'h01;
                r_wr_addr <= addr;
            end
            r_wr_pulse <= w_accept;
            r_rdata    <= w_rd_mux;
            r_txn_done <= w_act_fall;
            r_irq      <= |(r_status & r_irq_en);
        end
    end

    // Flatten CTRL registers onto the fabric bus.
    always_comb begin
        regs_out = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            regs_out[8*n +: 8] = r_ctrl[n];
        end
    end

    assign rdata    = r_rdata;
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign txn_done = r_txn_done;
    assign irq      = r_irq;

endmodule

// File: tb/tb_i2c_regmap_cdc.sv
// Directed + randomized bench for i2c_regmap_cdc against an address-map model.
module tb_i2c_regmap_cdc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en_wdata;
    logic [7:0]   addr;
    logic [7:0]   wdata;
    logic         i2c_active;
    logic [7:0]   hw_status;
    logic [7:0]   rdata;
    logic [127:0] regs_out;
    logic         wr_pulse;
    logic [7:0]   wr_addr;
    logic         txn_done;
    logic         irq;

    i2c_regmap_cdc dut (
        .clk(clk), .rst_n(rst_n), .wr_en_wdata(wr_en_wdata), .addr(addr),
        .wdata(wdata), .i2c_active(i2c_active), .hw_status(hw_status),
        .rdata(rdata), .regs_out(regs_out), .wr_pulse(wr_pulse),
        .wr_addr(wr_addr), .txn_done(txn_done), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;

    // Reference state
    logic [7:0] m_ctrl [16];
    logic [7:0] m_status, m_irq_en, m_cnt, m_last;

    always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_ctrl[i] = 8'h00;
        m_status = 8'h00; m_irq_en = 8'h00; m_cnt = 8'h00; m_last = 8'h00;
        exp_pulses = pulse_cnt;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        if (a < 8'd16)       return m_ctrl[a[3:0]];
        else if (a == 8'hF0) return m_status;
        else if (a == 8'hF1) return m_irq_en;
        else if (a == 8'hF2) return m_cnt;
        else if (a == 8'hFE) return 8'hA5;
        else                 return 8'h00;
    endfunction

    function automatic logic [127:0] m_pack();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m_ctrl[i];
        return r;
    endfunction

    // One slave write: random phase, pulse several clks, addr/wdata held well beyond
    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        #($urandom_range(0, 3));
        addr = a; wdata = d; wr_en_wdata = 1'b1;
        repeat (4) @(negedge clk);
        wr_en_wdata = 1'b0;
        repeat (8) @(negedge clk);
        if (a < 8'd16 || a == 8'hF0 || a == 8'hF1 || a == 8'hF2) begin
            exp_pulses++;
            m_last = a;
            if (a < 8'd16) m_ctrl[a[3:0]] = d;
            if (a == 8'hF0) m_status = m_status & ~d;
            if (a == 8'hF1) m_irq_en = d;
            m_cnt = (a == 8'hF2) ? 8'h00 : m_cnt + 8'h01;
        end
        m_status = m_status | hw_status;
    endtask

    task automatic read_check(input string tag, input logic [7:0] a);
        @(negedge clk);
        addr = a;
        @(negedge clk);
        check(tag, {120'd0, rdata}, {120'd0, m_read(a)});
    endtask

    task automatic hw_event(input logic [7:0] v);
        @(negedge clk);
        hw_status = v;
        @(negedge clk);
        hw_status = 8'h00;
        m_status = m_status | v;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".regs"}, regs_out, m_pack());
        check({tag, ".pulses"}, pulse_cnt, exp_pulses);
        check({tag, ".wr_addr"}, {120'd0, wr_addr}, {120'd0, m_last});
        check({tag, ".irq"}, {127'd0, irq}, {127'd0, |(m_status & m_irq_en)});
    endtask

    initial begin
        logic [7:0] a, d;
        int first, ntxn, base;

        rst_n = 1'b0; wr_en_wdata = 1'b0; addr = 8'h00; wdata = 8'h00;
        i2c_active = 1'b0; hw_status = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        check("rst.rdata", {120'd0, rdata}, 128'd0);
        check("rst.wr_pulse", {127'd0, wr_pulse}, 128'd0);
        check("rst.txn_done", {127'd0, txn_done}, 128'd0);
        check_state("rst");
        repeat (5) @(negedge clk);

        do_write(8'h03, 8'h5A);
        check("ctrl3", {120'd0, regs_out[31:24]}, {120'd0, 8'h5A});
        check_state("w3");
        read_check("cnt1", 8'hF2);

        do_write(8'hF2, 8'h00);
        for (int i = 0; i < 16; i++) do_write(8'(i), 8'($urandom));
        check_state("b2b");
        read_check("cnt16", 8'hF2);
        do_write(8'hF2, 8'h00);
        read_check("cnt_clr", 8'hF2);

        read_check("chip_id", 8'hFE);
        read_check("unmapped", 8'h80);
        do_write(8'hFE, 8'h00);
        check_state("wr_fe");
        read_check("chip_id2", 8'hFE);

        // Randomized mix of writes, reads and hardware events
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0: a = 8'($urandom_range(0, 15));
                1: a = 8'hF0;
                2: a = 8'hF1;
                3: a = 8'hF2;
                4: a = 8'hFE;
                default: a = 8'($urandom);
            endcase
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) hw_event(8'($urandom));
            do_write(a, d);
            check_state("rnd");
            read_check("rnd.rd", 8'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 15)));
            read_check("rnd.st", 8'hF0);
        end

        do_write(8'hF0, 8'hFF);
        do_write(8'hF1, 8'h01);
        hw_event(8'h01);
        read_check("st_set", 8'hF0);
        check_state("irq_on");
        hw_status = 8'h01;
        do_write(8'hF0, 8'h01);
        hw_status = 8'h00;
        read_check("st_setwins", 8'hF0);
        do_write(8'hF0, 8'h01);
        read_check("st_clr", 8'hF0);
        check_state("irq_off");

        do_write(8'hF2, 8'h00);
        for (int i = 0; i < 256; i++) do_write(8'($urandom_range(0, 15)), 8'($urandom));
        read_check("cnt_wrap", 8'hF2);
        do_write(8'h07, 8'h3C);
        read_check("cnt_257", 8'hF2);
        check_state("wrap");

        // Reset released while the write strobe is still high
        @(negedge clk);
        rst_n = 1'b0; addr = 8'h05; wdata = 8'h77; wr_en_wdata = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        base = pulse_cnt;
        repeat (8) @(negedge clk);
        wr_en_wdata = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wr.pulses", pulse_cnt, base);
        check("rst_wr.regs", regs_out, m_pack());

        i2c_active = 1'b1;
        repeat (6) @(negedge clk);
        i2c_active = 1'b0;
        first = 0; ntxn = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (txn_done === 1'b1) begin
                ntxn++;
                if (first == 0) first = k;
            end
        end
        check("txn.latency", first, 3);
        check("txn.count", ntxn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
